memmap_pdr: RTL

- Parametrised successor to the single-PAR page mapper.
- Translates 16-bit CPU virtual addresses to PA_W-bit physical addresses through per-mode PAR/PDR pairs (kernel, supervisor, user).
- Checks page length, access control and residency; on violation it aborts and freezes status register SR0.
- Sits between the CPU bus unit and the memory/IO decoder. It is also the register-file slave for the MMU I/O page registers.

---
 rtl/memmap_pdr.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/memmap_pdr.sv
// Page mapper with per-mode PAR/PDR pairs: translates 16-bit virtual addresses,
// checks length/access/residency, and freezes SR0 on the first abort.
module memmap_pdr #(
  parameter int unsigned PA_W   = 22,
  parameter int unsigned NMODES = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce,
  input  logic            regwr,
  input  logic            regrd,
  input  logic [5:0]      regaddr,
  input  logic [15:0]     data_i,
  output logic [15:0]     data_o,
  output logic            valid_o,
  input  logic [1:0]      mode,
  input  logic            req,
  input  logic            wr,
  input  logic [15:0]     vaddr,
  output logic            ack,
  output logic [PA_W-1:0] phaddr,
  output logic            abort,
  output logic [15:0]     sr0
);

  localparam int unsigned PARW      = PA_W - 6;
  localparam logic [15:0] SR0_WMASK = 16'hE06F;

  logic [PARW-1:0] par_q [3][8];
  logic [PARW-1:0] par_d [3][8];
  logic [6:0]      plf_q [3][8];
  logic [6:0]      plf_d [3][8];
  logic            w_q   [3][8];
  logic            w_d   [3][8];
  logic            ed_q  [3][8];
  logic            ed_d  [3][8];
  logic [1:0]      acf_q [3][8];
  logic [1:0]      acf_d [3][8];

  logic [15:0]     sr0_q, sr0_d;
  logic [15:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            ack_q, ack_d;
  logic            abort_q, abort_d;
  logic [PA_W-1:0] phaddr_q, phaddr_d;

  // Register-port decode
  logic [1:0]  rsp;
  logic [2:0]  rpg;
  logic        sp_ok;
  logic [15:0] rdata;

  always_comb begin
    rsp   = regaddr[5:4];
    rpg   = regaddr[2:0];
    sp_ok = (rsp != 2'd3) && !((rsp == 2'd1) && (NMODES < 3));
    rdata = '0;
    if (rsp == 2'd3) begin
      rdata = sr0_q;
    end else if (sp_ok) begin
      if (regaddr[3]) begin
        rdata[PARW-1:0] = par_q[rsp][rpg];
      end else begin
        rdata = {1'b0, plf_q[rsp][rpg], 1'b0, w_q[rsp][rpg], 2'b00,
                 ed_q[rsp][rpg], acf_q[rsp][rpg], 1'b0};
      end
    end
  end

  // Translation datapath
  logic [2:0]      pg;
  logic [6:0]      bn;
  logic [5:0]      bofs;
  logic [1:0]      msp;
  logic            mode_ok;
  logic [1:0]      sel_acf;
  logic [6:0]      sel_plf;
  logic            sel_ed;
  logic [PARW-1:0] sel_par;
  logic [2:0]      abt;      // {non-resident, length, read-only} -> SR0[15:13]
  logic [PA_W-1:0] xlat;

  always_comb begin
    pg      = vaddr[15:13];
    bn      = vaddr[12:6];
    bofs    = vaddr[5:0];
    msp     = 2'd0;
    mode_ok = 1'b1;
    case (mode)
      2'b00:   msp = 2'd0;
      2'b01: begin
        msp     = 2'd1;
        mode_ok = (NMODES > 2);
      end
      2'b11:   msp = 2'd2;
      default: mode_ok = 1'b0;
    endcase
    sel_acf = acf_q[msp][pg];
    sel_plf = plf_q[msp][pg];
    sel_ed  = ed_q[msp][pg];
    sel_par = par_q[msp][pg];
    abt     = '0;
    xlat    = '0;
    if (!sr0_q[0]) begin
      xlat[15:0] = vaddr;
      if (pg == 3'd7) xlat[PA_W-1:13] = '1;
    end else begin
      xlat = {sel_par + PARW'(bn), bofs};
      if (!mode_ok) begin
        abt[2] = 1'b1;
      end else begin
        abt[2] = !sel_acf[0];
        abt[1] = sel_ed ? (bn < sel_plf) : (bn > sel_plf);
        abt[0] = wr && (sel_acf == 2'b01);
      end
    end
  end

  // Software writes are applied last so they override same-cycle hardware updates.
  always_comb begin
    par_d    = par_q;
    plf_d    = plf_q;
    w_d      = w_q;
    ed_d     = ed_q;
    acf_d    = acf_q;
    sr0_d    = sr0_q;
    ack_d    = req;
    abort_d  = abort_q;
    phaddr_d = phaddr_q;
    valid_d  = regrd;
    data_d   = data_q;
    if (regrd) data_d = rdata;
    if (req) begin
      abort_d  = |abt;
      phaddr_d = xlat;
      if (|abt) begin
        if (sr0_q[15:13] == 3'b000) begin
          sr0_d[15:13] = abt;
          sr0_d[6:5]   = mode;
          sr0_d[3:1]   = pg;
        end
      end else if (sr0_q[0] && wr) begin
        w_d[msp][pg] = 1'b1;
      end
    end
    if (regwr) begin
      if (rsp == 2'd3) begin
        sr0_d = data_i & SR0_WMASK;
      end else if (sp_ok) begin
        if (regaddr[3]) begin
          par_d[rsp][rpg] = data_i[PARW-1:0];
        end else begin
          plf_d[rsp][rpg] = data_i[14:8];
          w_d[rsp][rpg]   = 1'b0;
          ed_d[rsp][rpg]  = data_i[3];
          acf_d[rsp][rpg] = data_i[2:1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned m = 0; m < 3; m++) begin
        for (int unsigned p = 0; p < 8; p++) begin
          par_q[m][p] <= '0;
          plf_q[m][p] <= '0;
          w_q[m][p]   <= 1'b0;
          ed_q[m][p]  <= 1'b0;
          acf_q[m][p] <= '0;
        end
      end
      sr0_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      abort_q  <= 1'b0;
      phaddr_q <= '0;
    end else if (ce) begin
      par_q    <= par_d;
      plf_q    <= plf_d;
      w_q      <= w_d;
      ed_q     <= ed_d;
      acf_q    <= acf_d;
      sr0_q    <= sr0_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      abort_q  <= abort_d;
      phaddr_q <= phaddr_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ack     = ack_q;
  assign abort   = abort_q;
  assign phaddr  = phaddr_q;
  assign sr0     = sr0_q;

endmodule
